// File: rtl/rvv_backend_pkg.sv
// Shared types and helpers for the RVV backend decode stage.
package rvv_backend_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } DE_CTRL_STATE_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/rvv_backend_decode_ctrl_chk.sv
// Protocol checker for the decode controller; assertions compile under ASSERT_ON.
module rvv_backend_decode_ctrl_chk #(
  parameter int NUM_DE_UOP = 4
)(
  input logic                  clk,
  input logic                  rst_n,
  input logic                  inst_valid_i,
  input logic                  flush_i,
  input logic [NUM_DE_UOP-1:0] valid_i,
  input logic [NUM_DE_UOP-1:0] last_i,
  input logic                  split_i,
  input logic                  k_nz_i,
  input logic                  pop_i,
  input logic                  ovf_i
);

  logic                  noncontig_s;
  logic [NUM_DE_UOP-1:0] vlast_s;
  logic                  multi_last_s;
  logic                  unused_ok;

  // A prefix mask plus one has no bits in common with the mask itself.
  assign noncontig_s  = |(valid_i & (valid_i + NUM_DE_UOP'(1)));
  assign vlast_s      = valid_i & last_i;
  assign multi_last_s = |(vlast_s & (vlast_s - NUM_DE_UOP'(1)));
  assign unused_ok    = &{1'b0, clk, rst_n, inst_valid_i, flush_i, split_i,
                          k_nz_i, pop_i, ovf_i, noncontig_s, multi_last_s};

`ifdef ASSERT_ON
  a_contig: assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_valid_i && noncontig_s))
    else $error("uop_valid_de2uq not prefix-contiguous");

  a_head_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !(split_i && !inst_valid_i && !flush_i))
    else $error("inst_valid_cq2de dropped during SPLIT");

  a_remain_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_valid_i && !flush_i && k_nz_i && !pop_i && ovf_i))
    else $error("uop_index_remain overflow");

  a_one_last: assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_valid_i && multi_last_s))
    else $error("multiple uop_last_de2uq bits in valid prefix");
`endif

endmodule

// File: rtl/rvv_backend_decode_ctrl_cnt.sv
// Grant logic: k = min(valid count, UQ free space) and the prefix push mask,
// truncated after the slot that carries the instruction's last uop.
module rvv_backend_decode_ctrl_cnt #(
  parameter int NUM_DE_UOP   = 4,
  parameter int UQ_CNT_WIDTH = 4,
  parameter int K_WIDTH      = $clog2(NUM_DE_UOP + 1)
)(
  input  logic                    en_i,
  input  logic [NUM_DE_UOP-1:0]   valid_i,
  input  logic [NUM_DE_UOP-1:0]   last_i,
  input  logic [UQ_CNT_WIDTH-1:0] free_i,
  output logic [K_WIDTH-1:0]      k_o,
  output logic [NUM_DE_UOP-1:0]   push_o,
  output logic                    pop_o
);

  localparam int CMP_WIDTH = (K_WIDTH > UQ_CNT_WIDTH) ? K_WIDTH : UQ_CNT_WIDTH;

  logic [K_WIDTH-1:0] n_valid_s;
  logic               seen_last_s;

  // Population count of the decoded uop valids.
  always_comb begin
    n_valid_s = '0;
    for (int i = 0; i < NUM_DE_UOP; i++) begin
      n_valid_s = n_valid_s + K_WIDTH'(valid_i[i]);
    end
  end

  // Number of uops the UQ can take this cycle.
  always_comb begin
    k_o = '0;
    if (!en_i) begin
      k_o = '0;
    end else if (CMP_WIDTH'(n_valid_s) <= CMP_WIDTH'(free_i)) begin
      k_o = n_valid_s;
    end else begin
      k_o = K_WIDTH'(free_i);
    end
  end

  // Push mask stops right after the last uop, which also triggers the CQ pop.
  always_comb begin
    push_o      = '0;
    seen_last_s = 1'b0;
    for (int i = 0; i < NUM_DE_UOP; i++) begin
      push_o[i]   = (K_WIDTH'(i) < k_o) && !seen_last_s;
      seen_last_s = seen_last_s | (push_o[i] & last_i[i]);
    end
    pop_o = seen_last_s;
  end

endmodule

// File: rtl/rvv_backend_decode_ctrl.sv
// Decode-stage sequencer between CQ and UQ. Optional DE_STALL_CNT_EN adds a
// saturating UQ-full stall counter; ASSERT_ON enables the protocol checker.
module rvv_backend_decode_ctrl
  import rvv_backend_pkg::*;
#(
  parameter int NUM_DE_UOP      = 4,
  parameter int UOP_INDEX_WIDTH = 3,
  parameter int UQ_CNT_WIDTH    = 4
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inst_valid_cq2de,
  input  logic                       trap_flush_rvv,
  input  logic [NUM_DE_UOP-1:0]      uop_valid_de2uq,
  input  logic [NUM_DE_UOP-1:0]      uop_last_de2uq,
  input  logic [UQ_CNT_WIDTH-1:0]    uq_free_cnt,
  output logic [UOP_INDEX_WIDTH-1:0] uop_index_remain,
  output logic [NUM_DE_UOP-1:0]      push_de2uq,
  output logic                       pop_de2cq
`ifdef DE_STALL_CNT_EN
  ,
  output logic [31:0]                de_stall_cnt
`endif
);

  localparam int K_WIDTH = $clog2(NUM_DE_UOP + 1);

  DE_CTRL_STATE_e             state_q, state_d;
  logic [UOP_INDEX_WIDTH-1:0] remain_q, remain_d;
  logic [UOP_INDEX_WIDTH:0]   remain_sum_s;
  logic [K_WIDTH-1:0]         k_s;
  logic [NUM_DE_UOP-1:0]      push_s;
  logic                       pop_s;
  logic                       en_s;

  assign en_s = inst_valid_cq2de & ~trap_flush_rvv;

  rvv_backend_decode_ctrl_cnt #(
    .NUM_DE_UOP   (NUM_DE_UOP),
    .UQ_CNT_WIDTH (UQ_CNT_WIDTH),
    .K_WIDTH      (K_WIDTH)
  ) u_cnt (
    .en_i    (en_s),
    .valid_i (uop_valid_de2uq),
    .last_i  (uop_last_de2uq),
    .free_i  (uq_free_cnt),
    .k_o     (k_s),
    .push_o  (push_s),
    .pop_o   (pop_s)
  );

  assign push_de2uq       = push_s;
  assign pop_de2cq        = pop_s;
  assign uop_index_remain = remain_q;
  // Carry bit is kept only for the overflow check; silicon wraps.
  assign remain_sum_s     = {1'b0, remain_q} + (UOP_INDEX_WIDTH + 1)'(k_s);

  // Next-state and remain-index update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    if (trap_flush_rvv) begin
      state_d  = IDLE;
      remain_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            state_d = IDLE;
          end else if (k_s != '0) begin
            state_d = SPLIT;
          end else begin
            state_d = IDLE;
          end
        end
        SPLIT: begin
          if (pop_s) begin
            state_d = IDLE;
          end else begin
            state_d = SPLIT;
          end
        end
        default: state_d = IDLE;
      endcase
      if (pop_s) begin
        remain_d = '0;
      end else if (k_s != '0) begin
        remain_d = remain_sum_s[UOP_INDEX_WIDTH-1:0];
      end else begin
        remain_d = remain_q;
      end
    end
  end

  // State and remain-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

`ifdef DE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_evt_s;

  assign stall_evt_s  = inst_valid_cq2de & (|uop_valid_de2uq) & (k_s == '0);
  assign de_stall_cnt = stall_q;

  // Saturating stall count; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (stall_evt_s) begin
      stall_d = sat_inc32(stall_q);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

  rvv_backend_decode_ctrl_chk #(
    .NUM_DE_UOP (NUM_DE_UOP)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_valid_i (inst_valid_cq2de),
    .flush_i      (trap_flush_rvv),
    .valid_i      (uop_valid_de2uq),
    .last_i       (uop_last_de2uq),
    .split_i      (state_q == SPLIT),
    .k_nz_i       (k_s != '0),
    .pop_i        (pop_s),
    .ovf_i        (remain_sum_s[UOP_INDEX_WIDTH])
  );

endmodule

// File: tb/tb_rvv_backend_decode_ctrl.sv
// Directed table-driven bench for rvv_backend_decode_ctrl (DE_STALL_CNT_EN optional).
module tb_rvv_backend_decode_ctrl;
  import rvv_backend_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       inst_valid_cq2de;
  logic       trap_flush_rvv;
  logic [3:0] uop_valid_de2uq;
  logic [3:0] uop_last_de2uq;
  logic [3:0] uq_free_cnt;
  logic [2:0] uop_index_remain;
  logic [3:0] push_de2uq;
  logic       pop_de2cq;
`ifdef DE_STALL_CNT_EN
  logic [31:0] de_stall_cnt;
`endif

  rvv_backend_decode_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst_valid_cq2de (inst_valid_cq2de),
    .trap_flush_rvv   (trap_flush_rvv),
    .uop_valid_de2uq  (uop_valid_de2uq),
    .uop_last_de2uq   (uop_last_de2uq),
    .uq_free_cnt      (uq_free_cnt),
    .uop_index_remain (uop_index_remain),
    .push_de2uq       (push_de2uq),
    .pop_de2cq        (pop_de2cq)
`ifdef DE_STALL_CNT_EN
    ,
    .de_stall_cnt     (de_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       fl;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [3:0] free;
    logic [3:0] push;
    logic       pop;
    logic [2:0] rem;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic fl, input logic [3:0] vld,
                       input logic [3:0] lst, input logic [3:0] free);
    inst_valid_cq2de = iv;
    trap_flush_rvv   = fl;
    uop_valid_de2uq  = vld;
    uop_last_de2uq   = lst;
    uq_free_cnt      = free;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //           iv    fl    vld      lst      free    push     pop   rem
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 4'b0000, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'b0011, 4'b0010, 4'd8, 4'b0011, 1'b1, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'd8, 4'b1111, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 1'b0, 4'b1111, 4'b1000, 4'd8, 4'b1111, 1'b1, 3'd4};
    tbl[4]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 4'b0000, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'd3, 4'b0111, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'd0, 4'b0000, 1'b0, 3'd3};
    tbl[7]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'd8, 4'b1111, 1'b0, 3'd3};
    tbl[8]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'd8, 4'b0001, 1'b1, 3'd7};
    tbl[9]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 4'b0000, 1'b0, 3'd0};
    tbl[10] = '{1'b1, 1'b0, 4'b1111, 4'b0100, 4'd8, 4'b0111, 1'b1, 3'd0};
    tbl[11] = '{1'b1, 1'b0, 4'b0011, 4'b0010, 4'd1, 4'b0001, 1'b0, 3'd0};
    tbl[12] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'd5, 4'b0001, 1'b1, 3'd1};
    tbl[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 4'b0000, 1'b0, 3'd0};
    tbl[14] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'd8, 4'b1111, 1'b0, 3'd0};
    tbl[15] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'd8, 4'b0000, 1'b0, 3'd4};
    tbl[16] = '{1'b1, 1'b0, 4'b0011, 4'b0010, 4'd8, 4'b0011, 1'b1, 3'd0};
    tbl[17] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'd0, 4'b0000, 1'b0, 3'd0};
    tbl[18] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 4'b0000, 1'b0, 3'd0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset remain", 32'(uop_index_remain), 32'd0);
    chk("reset push", 32'(push_de2uq), 32'd0);
    chk("reset pop", 32'(pop_de2cq), 32'd0);
    chk("reset state", 32'(dut.state_q), 32'(IDLE));
`ifdef DE_STALL_CNT_EN
    chk("reset stall", de_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].fl, tbl[i].vld, tbl[i].lst, tbl[i].free);
      #1;
      chk($sformatf("v%0d push", i), 32'(push_de2uq), 32'(tbl[i].push));
      chk($sformatf("v%0d pop", i), 32'(pop_de2cq), 32'(tbl[i].pop));
      chk($sformatf("v%0d remain", i), 32'(uop_index_remain), 32'(tbl[i].rem));
      if (i == 16) begin
        chk("post-flush state", 32'(dut.state_q), 32'(IDLE));
      end
    end
`ifdef DE_STALL_CNT_EN
    // stalls at vectors 6, 15 (flush with valid uops) and 17
    chk("stall count", de_stall_cnt, 32'd3);
`endif

    // Async reset in the middle of an 8-uop instruction.
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b1111, 4'b0000, 4'd8);
    @(negedge clk);
    #1;
    chk("pre-rst remain", 32'(uop_index_remain), 32'd4);
    chk("pre-rst state", 32'(dut.state_q), 32'(SPLIT));
    #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, 4'd8);
    #1;
    chk("async rst remain", 32'(uop_index_remain), 32'd0);
    chk("async rst state", 32'(dut.state_q), 32'(IDLE));
    chk("async rst push", 32'(push_de2uq), 32'd0);
    chk("async rst pop", 32'(pop_de2cq), 32'd0);
`ifdef DE_STALL_CNT_EN
    chk("async rst stall", de_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b0011, 4'b0010, 4'd8);
    #1;
    chk("post-rst push", 32'(push_de2uq), 32'b0011);
    chk("post-rst pop", 32'(pop_de2cq), 32'd1);
    chk("post-rst remain", 32'(uop_index_remain), 32'd0);

    // Contiguity flag, exercised with no instruction presented.
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b0101, 4'b0000, 4'd8);
    #1;
    chk("noncontig 0101", 32'(dut.u_chk.noncontig_s), 32'd1);
    chk("idle push", 32'(push_de2uq), 32'd0);
    drive(1'b0, 1'b0, 4'b0111, 4'b0000, 4'd8);
    #1;
    chk("contig 0111", 32'(dut.u_chk.noncontig_s), 32'd0);
    @(negedge clk);
    chk("final remain", 32'(uop_index_remain), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvv_backend_decode_ctrl.md
# rvv_backend_decode_ctrl

Sequencing controller between the command queue (CQ) and the uop queue (UQ), paired with the decode unit. Tracks how many uops of the CQ head instruction have been issued, feeds the decode unit the `uop_index_remain` start index, grants per-slot pushes into the UQ according to UQ free space, and pops the CQ head once the instruction's last uop is accepted. It is the only stateful element of the decode stage.

## Interface
Parameters:
- `NUM_DE_UOP`, 4, max uops decoded/pushed per cycle (from `rvv_backend.svh`)
- `UOP_INDEX_WIDTH`, 3, uop index width; max 8 uops per instruction
- `UQ_CNT_WIDTH`, 4, width of the UQ free-entry count

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `inst_valid_cq2de`  in  1  CQ head instruction valid
- `trap_flush_rvv`  in  1  synchronous flush of in-flight decode state
- `uop_valid_de2uq`  in  `NUM_DE_UOP`  decoded uop valids from the decode unit, prefix-contiguous from slot 0
- `uop_last_de2uq`  in  `NUM_DE_UOP`  slot holds the instruction's final uop
- `uq_free_cnt`  in  `UQ_CNT_WIDTH`  free UQ entries this cycle
- `uop_index_remain`  out  `UOP_INDEX_WIDTH`  index of the next uop to decode; registered
- `push_de2uq`  out  `NUM_DE_UOP`  per-slot UQ push enable; prefix-contiguous
- `pop_de2cq`  out  1  dequeue the CQ head
- `de_stall_cnt`  out  32  UQ-full stall counter; present only with `DE_STALL_CNT_EN`

## Operation
- `n_valid` = count of set `uop_valid_de2uq` bits. `k` = min(`n_valid`, `uq_free_cnt`) when `inst_valid_cq2de`=1 and no flush; otherwise 0.
- `push_de2uq[i]` = 1 for i < k.
- `pop_de2cq` = 1 iff some slot i < k has `uop_last_de2uq[i]`=1. Uops after the last slot are never pushed.
- FSM states:
  - IDLE: `uop_index_remain`=0.
  - SPLIT: part of the head instruction is already in the UQ.
- FSM transitions:
  - IDLE→SPLIT when k>0 and no pop.
  - SPLIT→IDLE on pop.
  - Any state→IDLE on flush.
  - All other cases hold state.
- Register update:
  - On pop: `uop_index_remain` ← 0.
  - On k>0 without pop: `uop_index_remain` ← `uop_index_remain` + k. Unsigned add; the sum never exceeds 7. An overflow is an assertion error, and the value wraps in silicon.
  - On k=0: hold.
- Flush has priority over all events. When `trap_flush_rvv`=1: `push_de2uq`=0, `pop_de2cq`=0, next `uop_index_remain`=0, next state IDLE.
- UQ full (`uq_free_cnt`=0) with valid uops: no push, state held. `de_stall_cnt` increments when `DE_STALL_CNT_EN` is defined.
- Partial acceptance (0<k<`n_valid`): the remaining uops are re-decoded next cycle from the new `uop_index_remain`.
- Assertions under `ASSERT_ON`:
  - `uop_valid_de2uq` is non-contiguous.
  - `inst_valid_cq2de` drops while in SPLIT without a flush.
  - The remain-index add overflows.
  - More than one set `uop_last_de2uq` bit within the valid prefix.

## Timing
- Reset values: `uop_index_remain`=0, state IDLE, `de_stall_cnt`=0. `push_de2uq`=0 and `pop_de2cq`=0 while `inst_valid_cq2de`=0.
- `push_de2uq` and `pop_de2cq` are combinational from inputs and state, with zero latency. The UQ and CQ sample them on the same `clk` edge.
- `uop_index_remain` is visible one cycle after the push that advances it.
- Throughput: an N-uop instruction with an always-free UQ pops after ceil(N/`NUM_DE_UOP`) cycles. A new instruction can start the cycle after a pop.
- Async reset mid-instruction returns to IDLE immediately. The CQ head re-decodes from index 0.

## Configuration
- `DE_STALL_CNT_EN` defined:
  - Adds the `de_stall_cnt` port, a 32-bit saturating counter.
  - Increments on every cycle with `inst_valid_cq2de`=1, `n_valid`>0 and k=0.
  - Cleared by reset only; flush does not clear it.
- `DE_STALL_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- The FSM state enum `DE_CTRL_STATE_e` {IDLE, SPLIT} goes in `rvv_backend_pkg`, alongside the existing `NUM_DE_UOP` and `UOP_INDEX_WIDTH` macros in `rvv_backend.svh`.
- One sub-module: `rvv_backend_decode_ctrl_cnt`, a combinational prefix popcount plus min(`n_valid`, `uq_free_cnt`) producing k and the push mask.
- Instantiated beside `rvv_backend_decode_unit`, sharing the CQ head and UQ interfaces.

## Test plan
- 2-uop instruction, `uq_free_cnt`=8: cycle 0 pushes 4'b0011 with `pop_de2cq`=1; `uop_index_remain` stays 0.
- 8-uop instruction, `uq_free_cnt`=8:
  - cycle 0 pushes 4'b1111 with no pop, and `uop_index_remain`=4 next cycle;
  - cycle 1 pushes 4'b1111 with pop, and `uop_index_remain`=0.
- 8-uop instruction, `uq_free_cnt`=3 then 0 then 8:
  - cycle 0 pushes 4'b0111 and remain becomes 3;
  - cycle 1 pushes 0 (stall count +1 with `DE_STALL_CNT_EN`);
  - cycle 2 pushes 4'b1111 and remain becomes 7;
  - cycle 3 pushes 4'b0001 with pop.
- In SPLIT with remain=4, assert `trap_flush_rvv` together with valid uops: push=0, pop=0, and next cycle remain=0 in IDLE.
- Assert `rst_n` low asynchronously mid-cycle while remain=4: remain=0 and outputs inactive before the next edge. Also check the prefix-contiguity assertion fires on `uop_valid_de2uq`=4'b0101.
